// File: rtl/rtc_alarm_ctrl.sv
// RTC alarm controller: per-channel masked time-field alarms with sticky pending
// bits, level or pulse interrupt, and an async-event timestamp capture register.
module rtc_alarm_ctrl #(
  parameter  int NUM_CH    = 4,
  parameter  int IRQ_PULSE = 0,
  localparam int TIME_W    = 43
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [TIME_W-1:0]        cur_time_i,
  input  logic [NUM_CH*TIME_W-1:0] alarm_time_i,
  input  logic [NUM_CH*8-1:0]      alarm_mask_i,
  input  logic [NUM_CH-1:0]        ch_en_i,
  input  logic [NUM_CH-1:0]        irq_en_i,
  input  logic [NUM_CH-1:0]        clr_i,
  input  logic                     ir_i,
  input  logic                     stamp_ack_i,
  output logic [NUM_CH-1:0]        pending_o,
  output logic                     ir_o,
  output logic [TIME_W-1:0]        stamp_o,
  output logic                     stamp_valid_o,
  output logic                     stamp_ovf_o
);

  logic [TIME_W-1:0] cur_q;
  logic              started_q;
  logic              tick;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] pend_nxt;
  logic              irq_nxt;
  logic [2:0]        ir_sync_q;
  logic              ir_edge;

  // Only a change of time can fire, so a held value matches exactly once.
  assign tick = started_q && (cur_time_i != cur_q);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rtc_alarm_match u_match (
      .alarm_time (alarm_time_i[g*TIME_W +: TIME_W]),
      .cur_time   (cur_time_i),
      .mask       (alarm_mask_i[g*8 +: 8]),
      .en         (ch_en_i[g]),
      .match      (match[g])
    );
  end

  // Set beats clear when both land in the same cycle.
  assign pend_nxt = (pending_o & ~clr_i) | (match & {NUM_CH{tick}});

  if (IRQ_PULSE != 0) begin : g_irq_pulse
    assign irq_nxt = |(pend_nxt & ~pending_o & irq_en_i);
  end else begin : g_irq_level
    assign irq_nxt = |(pend_nxt & irq_en_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cur_q     <= '0;
      started_q <= 1'b0;
      pending_o <= '0;
      ir_o      <= 1'b0;
    end else begin
      cur_q     <= cur_time_i;
      started_q <= 1'b1;
      pending_o <= pend_nxt;
      ir_o      <= irq_nxt;
    end
  end

  // Two-flop synchroniser plus one history flop for rising-edge detection.
  assign ir_edge = ir_sync_q[1] & ~ir_sync_q[2];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ir_sync_q     <= '0;
      stamp_o       <= '0;
      stamp_valid_o <= 1'b0;
      stamp_ovf_o   <= 1'b0;
    end else begin
      ir_sync_q <= {ir_sync_q[1:0], ir_i};
      if (ir_edge && (!stamp_valid_o || stamp_ack_i)) begin
        stamp_o       <= cur_time_i;
        stamp_valid_o <= 1'b1;
      end else if (stamp_ack_i) begin
        stamp_valid_o <= 1'b0;
      end
      if (stamp_ack_i)
        stamp_ovf_o <= 1'b0;
      else if (ir_edge && stamp_valid_o)
        stamp_ovf_o <= 1'b1;
    end
  end

endmodule

// Per-channel field comparator; an all-zero mask never matches.
module rtc_alarm_match (
  input  logic [42:0] alarm_time,
  input  logic [42:0] cur_time,
  input  logic [7:0]  mask,
  input  logic        en,
  output logic        match
);

  typedef struct packed {
    logic [11:0] year;
    logic [3:0]  month;
    logic [4:0]  dom;
    logic [2:0]  dow;
    logic [1:0]  mode;
    logic [4:0]  hour;
    logic [5:0]  min;
    logic [5:0]  sec;
  } rtc_time_t;

  rtc_time_t  a;
  rtc_time_t  t;
  logic [7:0] eq;

  assign a  = alarm_time;
  assign t  = cur_time;
  assign eq = {a.year == t.year, a.month == t.month, a.dom == t.dom, a.dow == t.dow,
               a.mode == t.mode, a.hour == t.hour, a.min == t.min, a.sec == t.sec};

  assign match = en & (|mask) & (&(eq | ~mask));

endmodule

// File: tb/tb_rtc_alarm_ctrl.sv
// Bench for rtc_alarm_ctrl: three instances (4ch level, 8ch pulse, 1ch level)
// driven together and checked against a field-level behavioural model.
module tb_rtc_alarm_ctrl;
  localparam int TW = 43;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [TW-1:0] cur_time = '0;
  logic          ir_in = 1'b0;
  logic          ack = 1'b0;
  logic [TW-1:0] al [3][8];
  logic [7:0]    mk [3][8];
  logic [7:0]    en [3];
  logic [7:0]    ie [3];
  logic [7:0]    cl [3];

  logic [4*TW-1:0] a_alarm;
  logic [31:0]     a_mask;
  logic [8*TW-1:0] b_alarm;
  logic [63:0]     b_mask;
  logic [TW-1:0]   c_alarm;
  logic [7:0]      c_mask;

  always_comb begin
    a_alarm = '0; a_mask = '0;
    for (int c = 0; c < 4; c++) begin a_alarm[c*TW +: TW] = al[0][c]; a_mask[c*8 +: 8] = mk[0][c]; end
  end
  always_comb begin
    b_alarm = '0; b_mask = '0;
    for (int c = 0; c < 8; c++) begin b_alarm[c*TW +: TW] = al[1][c]; b_mask[c*8 +: 8] = mk[1][c]; end
  end
  assign c_alarm = al[2][0];
  assign c_mask  = mk[2][0];

  logic [3:0] a_pend; logic a_ir, a_sv, a_ovf; logic [TW-1:0] a_st;
  logic [7:0] b_pend; logic b_ir, b_sv, b_ovf; logic [TW-1:0] b_st;
  logic [0:0] c_pend; logic c_ir, c_sv, c_ovf; logic [TW-1:0] c_st;

  rtc_alarm_ctrl #(.NUM_CH(4), .IRQ_PULSE(0)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .cur_time_i(cur_time), .alarm_time_i(a_alarm),
    .alarm_mask_i(a_mask), .ch_en_i(en[0][3:0]), .irq_en_i(ie[0][3:0]), .clr_i(cl[0][3:0]),
    .ir_i(ir_in), .stamp_ack_i(ack), .pending_o(a_pend), .ir_o(a_ir), .stamp_o(a_st),
    .stamp_valid_o(a_sv), .stamp_ovf_o(a_ovf));

  rtc_alarm_ctrl #(.NUM_CH(8), .IRQ_PULSE(1)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .cur_time_i(cur_time), .alarm_time_i(b_alarm),
    .alarm_mask_i(b_mask), .ch_en_i(en[1]), .irq_en_i(ie[1]), .clr_i(cl[1]),
    .ir_i(ir_in), .stamp_ack_i(ack), .pending_o(b_pend), .ir_o(b_ir), .stamp_o(b_st),
    .stamp_valid_o(b_sv), .stamp_ovf_o(b_ovf));

  rtc_alarm_ctrl #(.NUM_CH(1), .IRQ_PULSE(0)) dut_c (
    .clk_i(clk), .rstn_i(rstn), .cur_time_i(cur_time), .alarm_time_i(c_alarm),
    .alarm_mask_i(c_mask), .ch_en_i(en[2][0:0]), .irq_en_i(ie[2][0:0]), .clr_i(cl[2][0:0]),
    .ir_i(ir_in), .stamp_ack_i(ack), .pending_o(c_pend), .ir_o(c_ir), .stamp_o(c_st),
    .stamp_valid_o(c_sv), .stamp_ovf_o(c_ovf));

  // Observed outputs gathered per instance for uniform comparison loops.
  logic [7:0] op [3]; logic oir [3]; logic [TW-1:0] ost [3]; logic osv [3]; logic oovf [3];
  always_comb begin
    op[0] = {4'b0, a_pend}; op[1] = b_pend; op[2] = {7'b0, c_pend};
    oir[0] = a_ir; oir[1] = b_ir; oir[2] = c_ir;
    ost[0] = a_st; ost[1] = b_st; ost[2] = c_st;
    osv[0] = a_sv; osv[1] = b_sv; osv[2] = c_sv;
    oovf[0] = a_ovf; oovf[1] = b_ovf; oovf[2] = c_ovf;
  end

  int errors = 0;
  int checks = 0;
  int nch [3] = '{4, 8, 1};
  int pls [3] = '{0, 1, 0};

  // Reference model state.
  bit [7:0]      mp [3];
  bit            mir [3];
  logic [TW-1:0] mst, mprev;
  bit            msv, movf, mstart, mh1, mh2, mh3;

  function automatic logic [TW-1:0] tm(int yr, int mo, int dm, int dw, int md, int hr, int mi, int sc);
    return {yr[11:0], mo[3:0], dm[4:0], dw[2:0], md[1:0], hr[4:0], mi[5:0], sc[5:0]};
  endfunction

  function automatic bit fmatch(logic [TW-1:0] a, logic [TW-1:0] t, logic [7:0] m);
    int lo [8] = '{0, 6, 12, 17, 19, 22, 27, 31};
    int w  [8] = '{6, 6, 5, 2, 3, 5, 4, 12};
    bit ok = (m != 8'd0);
    for (int f = 0; f < 8; f++)
      if (m[f] && ((((a ^ t) >> lo[f]) & ((43'd1 << w[f]) - 43'd1)) != 43'd0)) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin mp[d] = '0; mir[d] = 1'b0; end
    mst = '0; mprev = '0; msv = 0; movf = 0; mstart = 0; mh1 = 0; mh2 = 0; mh3 = 0;
  endtask

  // One clock: the model takes the inputs present before the edge.
  task automatic cycle();
    bit chg, fire, ev, nsv, novf, nh1;
    bit [7:0] np [3];
    bit nir [3];
    logic [TW-1:0] nst;
    chg = mstart && (cur_time != mprev);
    for (int d = 0; d < 3; d++) begin
      np[d] = '0;
      for (int c = 0; c < nch[d]; c++) begin
        fire = chg && en[d][c] && fmatch(al[d][c], cur_time, mk[d][c]);
        np[d][c] = fire | (mp[d][c] & ~cl[d][c]);
      end
      nir[d] = (pls[d] != 0) ? |(np[d] & ~mp[d] & ie[d]) : |(np[d] & ie[d]);
    end
    ev = mh2 & ~mh3; nst = mst; nsv = msv; novf = movf; nh1 = ir_in;
    if (ev && (!msv || ack)) begin nst = cur_time; nsv = 1; end
    else if (ack) nsv = 0;
    if (ack) novf = 0; else if (ev && msv) novf = 1;
    @(posedge clk);
    mp = np; mir = nir; mst = nst; msv = nsv; movf = novf;
    mprev = cur_time; mstart = 1; mh3 = mh2; mh2 = mh1; mh1 = nh1;
    #1;
    for (int d = 0; d < 3; d++) cl[d] = '0;
    ack = 1'b0;
  endtask

  task automatic clear_cfg();
    for (int d = 0; d < 3; d++) begin
      en[d] = '0; ie[d] = '0; cl[d] = 8'hFF;
      for (int c = 0; c < 8; c++) begin al[d][c] = '0; mk[d][c] = '0; end
    end
    ack = 1'b1; ir_in = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    logic [TW-1:0] t;
    t = tm(2030, 5, 10, 2, 1, 12, 0, 0);
    cur_time = t;
    for (int d = 0; d < 3; d++) begin al[d][0] = t; mk[d][0] = 8'hFF; en[d] = 8'h01; ie[d] = 8'h01; end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      checks++; if (op[d] !== 8'h00) begin errors++; $display("FAIL reset_pend[%0d]: got %h expected 00", d, op[d]); end
      checks++; if ({oir[d], osv[d], oovf[d]} !== 3'b000) begin errors++; $display("FAIL reset_flags[%0d]: got %b expected 000", d, {oir[d], osv[d], oovf[d]}); end
      checks++; if (ost[d] !== '0) begin errors++; $display("FAIL reset_stamp[%0d]: got %h expected 0", d, ost[d]); end
    end
    rstn = 1'b1;
    model_reset();
    repeat (5) cycle();
    for (int d = 0; d < 3; d++) begin
      checks++; if ({op[d], oir[d]} !== 9'h0) begin errors++; $display("FAIL release_match[%0d]: got pend=%h ir=%b expected 0", d, op[d], oir[d]); end
    end
  endtask

  task automatic test_sec_alarm();
    int refire;
    clear_cfg();
    al[0][0] = tm(0, 0, 0, 0, 0, 0, 0, 30); mk[0][0] = 8'h01; en[0] = 8'h01; ie[0] = 8'h01;
    cur_time = tm(0, 0, 0, 0, 0, 0, 0, 29);
    cycle(); cycle();
    checks++; if (a_pend[0] !== 1'b0) begin errors++; $display("FAIL sec29_pend: got %b expected 0", a_pend[0]); end
    cur_time = tm(0, 0, 0, 0, 0, 0, 0, 30);
    cycle();
    checks++; if (a_pend[0] !== 1'b1) begin errors++; $display("FAIL sec30_pend: got %b expected 1", a_pend[0]); end
    checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL sec30_irq: got %b expected 1", a_ir); end
    repeat (10) cycle();
    cl[0] = 8'h01;
    cycle();
    checks++; if ({a_pend[0], a_ir} !== 2'b00) begin errors++; $display("FAIL sec30_clr: got %b expected 00", {a_pend[0], a_ir}); end
    refire = 0;
    repeat (89) begin cycle(); if (a_pend[0] || a_ir) refire++; end
    checks++; if (refire !== 0) begin errors++; $display("FAIL sec30_hold_refire: got %0d cycles expected 0", refire); end
  endtask

  task automatic test_clr_collision();
    cur_time = tm(0, 0, 0, 0, 0, 0, 0, 31); cycle();
    cur_time = tm(0, 0, 0, 0, 0, 0, 0, 30); cycle();
    checks++; if (a_pend[0] !== 1'b1) begin errors++; $display("FAIL coll_set: got %b expected 1", a_pend[0]); end
    cur_time = tm(0, 0, 0, 0, 0, 0, 0, 31); cycle();
    cur_time = tm(0, 0, 0, 0, 0, 0, 0, 30); cl[0] = 8'h01; cycle();
    checks++; if (a_pend[0] !== 1'b1) begin errors++; $display("FAIL coll_set_wins: got %b expected 1", a_pend[0]); end
    cl[0] = 8'h01; cycle();
    checks++; if (a_pend[0] !== 1'b0) begin errors++; $display("FAIL coll_plain_clr: got %b expected 0", a_pend[0]); end
  endtask

  task automatic test_pulse_irq();
    int hi;
    clear_cfg();
    for (int c = 0; c < 2; c++) begin al[1][c] = tm(0, 0, 0, 0, 0, 0, 10, 0); mk[1][c] = 8'h02; end
    en[1] = 8'h03; ie[1] = 8'h03;
    cur_time = tm(0, 0, 0, 0, 0, 0, 9, 0); cycle();
    cur_time = tm(0, 0, 0, 0, 0, 0, 10, 0); cycle();
    checks++; if (b_ir !== 1'b1) begin errors++; $display("FAIL pulse_first: got %b expected 1", b_ir); end
    checks++; if (b_pend !== 8'h03) begin errors++; $display("FAIL pulse_pend: got %h expected 03", b_pend); end
    hi = 0;
    repeat (10) begin cycle(); if (b_ir) hi++; end
    checks++; if (hi !== 0) begin errors++; $display("FAIL pulse_width: got %0d extra cycles expected 0", hi); end
    checks++; if (b_pend !== 8'h03) begin errors++; $display("FAIL pulse_sticky: got %h expected 03", b_pend); end
  endtask

  task automatic test_stamp();
    logic [TW-1:0] t5;
    clear_cfg();
    t5 = tm(0, 0, 0, 0, 0, 0, 0, 5);
    cur_time = t5; ir_in = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      cycle();
      for (int d = 0; d < 3; d++) begin
        checks++; if (osv[d] !== (e == 3)) begin errors++; $display("FAIL stamp_lat_e%0d[%0d]: got %b expected %b", e, d, osv[d], e == 3); end
      end
    end
    for (int d = 0; d < 3; d++) begin
      checks++; if (ost[d] !== t5) begin errors++; $display("FAIL stamp_val[%0d]: got %h expected %h", d, ost[d], t5); end
    end
    ir_in = 1'b0; repeat (3) cycle();
    cur_time = tm(0, 0, 0, 0, 0, 0, 0, 6); ir_in = 1'b1; repeat (4) cycle(); ir_in = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checks++; if ({osv[d], oovf[d]} !== 2'b11) begin errors++; $display("FAIL stamp_ovf[%0d]: got %b expected 11", d, {osv[d], oovf[d]}); end
      checks++; if (ost[d] !== t5) begin errors++; $display("FAIL stamp_keep[%0d]: got %h expected %h", d, ost[d], t5); end
    end
    ack = 1'b1; cycle();
    for (int d = 0; d < 3; d++) begin
      checks++; if ({osv[d], oovf[d]} !== 2'b00) begin errors++; $display("FAIL stamp_ack[%0d]: got %b expected 00", d, {osv[d], oovf[d]}); end
    end
  endtask

  task automatic test_full_date();
    logic [TW-1:0] t;
    logic [TW-1:0] v [8];
    clear_cfg();
    t = tm(2024, 12, 31, 3, 1, 23, 59, 59);
    v[0] = tm(2023, 12, 31, 3, 1, 23, 59, 59); v[1] = tm(2024, 11, 31, 3, 1, 23, 59, 59);
    v[2] = tm(2024, 12, 30, 3, 1, 23, 59, 59); v[3] = tm(2024, 12, 31, 2, 1, 23, 59, 59);
    v[4] = tm(2024, 12, 31, 3, 0, 23, 59, 59); v[5] = tm(2024, 12, 31, 3, 1, 22, 59, 59);
    v[6] = tm(2024, 12, 31, 3, 1, 23, 58, 59); v[7] = tm(2024, 12, 31, 3, 1, 23, 59, 58);
    al[2][0] = t; mk[2][0] = 8'hFF; en[2] = 8'h01; ie[2] = 8'h01;
    al[1][7] = t; mk[1][7] = 8'hFF; al[1][6] = t; mk[1][6] = 8'h00; en[1] = 8'hC0; ie[1] = 8'hC0;
    for (int i = 0; i < 8; i++) begin
      cur_time = v[i]; cycle();
      checks++; if ({c_pend[0], b_pend[7]} !== 2'b00) begin errors++; $display("FAIL date_near%0d: got %b expected 00", i, {c_pend[0], b_pend[7]}); end
    end
    cur_time = t; cycle();
    checks++; if ({c_pend[0], c_ir} !== 2'b11) begin errors++; $display("FAIL date_ch1: got %b expected 11", {c_pend[0], c_ir}); end
    checks++; if ({b_pend[7:6], b_ir} !== 3'b101) begin errors++; $display("FAIL date_ch8: got %b expected 101", {b_pend[7:6], b_ir}); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      if (n % 200 == 0)
        for (int d = 0; d < 3; d++)
          for (int c = 0; c < 8; c++) begin
            al[d][c] = tm($urandom_range(1), 1, 1, $urandom_range(1), 0, $urandom_range(1), $urandom_range(1), $urandom_range(3));
            mk[d][c] = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
          end
      if (n % 50 == 0) for (int d = 0; d < 3; d++) begin en[d] = 8'($urandom); ie[d] = 8'($urandom); end
      if ($urandom_range(2) != 0)
        cur_time = tm($urandom_range(1), 1, 1, $urandom_range(1), 0, $urandom_range(1), $urandom_range(1), $urandom_range(3));
      for (int d = 0; d < 3; d++) cl[d] = ($urandom_range(5) == 0) ? 8'($urandom) : 8'h00;
      ack = ($urandom_range(6) == 0);
      if ($urandom_range(3) == 0) ir_in = ~ir_in;
      if ($urandom_range(299) == 0) begin
        #3 rstn = 1'b0; model_reset();
        #1;
        checks++; if ({a_pend, b_pend, c_pend, a_ir, b_ir, c_ir, a_sv, b_sv, c_sv} !== 22'h0) begin
          errors++; $display("FAIL rand_async_reset: got %h expected 0", {a_pend, b_pend, c_pend, a_ir, b_ir, c_ir, a_sv, b_sv, c_sv}); end
        @(posedge clk); #1 rstn = 1'b1;
        for (int d = 0; d < 3; d++) cl[d] = '0;
        ack = 1'b0;
      end else begin
        cycle();
      end
      for (int d = 0; d < 3; d++) begin
        checks++; if (op[d] !== mp[d]) begin errors++; $display("FAIL rand_pend[%0d] n=%0d: got %h expected %h", d, n, op[d], mp[d]); end
        checks++; if (oir[d] !== mir[d]) begin errors++; $display("FAIL rand_irq[%0d] n=%0d: got %b expected %b", d, n, oir[d], mir[d]); end
        checks++; if ({osv[d], oovf[d]} !== {msv, movf}) begin errors++; $display("FAIL rand_stflags[%0d] n=%0d: got %b expected %b", d, n, {osv[d], oovf[d]}, {msv, movf}); end
        checks++; if (ost[d] !== mst) begin errors++; $display("FAIL rand_stamp[%0d] n=%0d: got %h expected %h", d, n, ost[d], mst); end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      en[d] = '0; ie[d] = '0; cl[d] = '0;
      for (int c = 0; c < 8; c++) begin al[d][c] = '0; mk[d][c] = '0; end
    end
    model_reset();
    test_reset();
    test_sec_alarm();
    test_clr_collision();
    test_pulse_irq();
    test_stamp();
    test_full_date();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtc_alarm_ctrl.md
RTC_ALARM_CTRL -- requirements
Module: rtc_alarm_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of alarm channels, legal range 1..8.
REQ-002 SHALL have parameter IRQ_PULSE, default 0; 0 = level interrupt, 1 = one-cycle pulse interrupt.
REQ-003 SHALL define localparam TIME_W = 43; packed time = {year[11:0], month[3:0], dom[4:0], dow[2:0], mode[1:0], hour[4:0], min[5:0], sec[5:0]}, sec at LSB.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rstn_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port cur_time_i, input, TIME_W: current packed time, synchronous to clk_i.
REQ-007 SHALL have port alarm_time_i, input, NUM_CH*TIME_W: per-channel alarm time; channel c at [c*TIME_W +: TIME_W].
REQ-008 SHALL have port alarm_mask_i, input, NUM_CH*8: per-channel field compare enables; bit order [0]sec [1]min [2]hour [3]mode [4]dow [5]dom [6]month [7]year.
REQ-009 SHALL have port ch_en_i, input, NUM_CH: channel enable.
REQ-010 SHALL have port irq_en_i, input, NUM_CH: per-channel interrupt enable.
REQ-011 SHALL have port clr_i, input, NUM_CH: one-cycle write-1-to-clear pulses for pending bits.
REQ-012 SHALL have port ir_i, input, 1: asynchronous external event for timestamp capture.
REQ-013 SHALL have port stamp_ack_i, input, 1: one-cycle acknowledge of the captured timestamp.
REQ-014 SHALL have port pending_o, output, NUM_CH: sticky per-channel alarm pending.
REQ-015 SHALL have port ir_o, output, 1: interrupt request.
REQ-016 SHALL have port stamp_o, output, TIME_W: captured time.
REQ-017 SHALL have port stamp_valid_o, output, 1: stamp_o holds unacknowledged capture.
REQ-018 SHALL have port stamp_ovf_o, output, 1: event lost while stamp_valid_o was high.

Function
REQ-019 SHALL register cur_time_i into cur_q every cycle; tick = (cur_time_i != cur_q) AND first-cycle flag clear.
REQ-020 SHALL suppress tick on the first clock after reset release (loads cur_q only, sets flag).
REQ-021 SHALL compute per-channel match = ch_en_i[c] AND |mask[c] AND every masked field of alarm equals cur_time_i; all-zero mask never matches.
REQ-022 SHALL set pending[c] at the edge ending a cycle with tick AND match[c] (visible one cycle after cur_time_i changes); a time value fires at most once.
REQ-023 SHALL clear pending[c] on clr_i[c]; simultaneous set and clear: set wins.
REQ-024 SHALL keep pending set regardless of ch_en_i/irq_en_i changes until cleared.
REQ-025 SHALL, IRQ_PULSE=0, register ir_o = |(pending_next & irq_en_i), same edge as pending_o.
REQ-026 SHALL, IRQ_PULSE=1, register ir_o high for exactly one cycle when any pending bit with irq_en_i set transitions 0->1; no retrigger while it stays set.
REQ-027 SHALL synchronise ir_i through two flops and detect rising edge on synchronised value; stamp_valid_o rises 3 edges after the first edge sampling ir_i high.
REQ-028 SHALL, on detected edge with stamp_valid_o low, load stamp_o <= cur_time_i and set stamp_valid_o.
REQ-029 SHALL, on detected edge with stamp_valid_o high and no ack, keep stamp_o and set stamp_ovf_o (sticky).
REQ-030 SHALL, on stamp_ack_i, clear stamp_valid_o and stamp_ovf_o; ack with simultaneous edge: capture new value, stamp_valid_o stays 1, ovf cleared.

Reset
REQ-031 SHALL on rstn_i low immediately clear pending_o, ir_o, stamp_o, stamp_valid_o, stamp_ovf_o, cur_q, sync flops, first-cycle flag.
REQ-032 SHALL, on reset mid-operation, discard pending/stamp state with no interrupt glitch after release.

Verification
REQ-033 SHALL cover: ch0 alarm sec=30 mask=0x01, cur_time sec 29->30 -> pending_o[0]=1 and ir_o=1 next cycle; held at 30 for 100 cycles -> no refire after clr.
REQ-034 SHALL cover: clr_i[0] same cycle as new match -> pending_o[0] stays 1.
REQ-035 SHALL cover: IRQ_PULSE=1, two channels match same tick -> ir_o high exactly 1 cycle, pending_o=0b11.
REQ-036 SHALL cover: reset release with cur_time_i equal to alarm -> no pending, ir_o=0.
REQ-037 SHALL cover: ir_i pulse at sec=5 -> stamp_valid_o=1 after 3 edges, stamp_o sec=5; second pulse before ack -> stamp_ovf_o=1, stamp_o unchanged; ack -> both cleared.
REQ-038 SHALL cover: NUM_CH=1 and NUM_CH=8, mask 0xFF full-date alarm (year 2024, month 12, dom 31, 23:59:59) -> fires only on exact match.
